countdown_timer: RTL

Synchronous loadable down-counter with run/stop control and a terminal-count pulse. It is the counterpart of the team's up-counting ripple counter: software or a controller loads a count, starts the block, and is told when the count expires. Each bit is a toggle cell with a borrow chain, but all state is clocked on one edge, so there is no ripple clocking. The block sits beside the up-counter as the timeout/interval source in the same designs.

---
 rtl/countdown_pkg.sv | 14 +
 rtl/countdown_timer_down_cell.sv | 28 ++
 rtl/countdown_timer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and reset values for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam logic   FLAG_RST  = 1'b0;
  localparam logic   Q_BIT_RST = 1'b0;

endpackage

// File: rtl/countdown_timer_down_cell.sv
// One bit of the down-counter: loadable toggle cell with a combinational borrow chain.
module down_cell
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_bit,
  input  logic en,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= Q_BIT_RST;
    end else if (load) begin
      q <= load_bit;
    end else if (en && borrow_in) begin
      q <= ~q;
    end
  end

  // A zero bit passes the borrow upward; a one bit absorbs it.
  assign borrow_out = borrow_in & ~q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with run/stop control and a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the reload register on expiry instead of stopping in DONE.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] cell_data;
  logic [WIDTH:0]   borrow;
  logic             cell_load, dec_en, reload_we, tc_next;
  logic             q_zero, q_one;

  // Borrow that survives every cell means all bits are zero.
  assign borrow[0] = 1'b1;
  assign q_zero    = borrow[WIDTH];
  assign q_one     = (q == WIDTH'(1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    down_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .load       (cell_load),
      .load_bit   (cell_data[i]),
      .en         (dec_en),
      .borrow_in  (borrow[i]),
      .q          (q[i]),
      .borrow_out (borrow[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_RST;
    end else begin
      state <= state_next;
    end
  end

  // Next state and cell controls; request priority is stop > load > start.
  always_comb begin
    state_next = state;
    cell_load  = 1'b0;
    cell_data  = load_val;
    dec_en     = 1'b0;
    reload_we  = 1'b0;
    tc_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (load) begin
          cell_load = 1'b1;
          reload_we = 1'b1;
        end else if (start) begin
          if (q_zero) begin
            state_next = DONE;
            tc_next    = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (q_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          cell_load = 1'b1;
          cell_data = reload;
          tc_next   = (reload == '0);
`else
          state_next = DONE;
          tc_next    = 1'b1;
`endif
        end else begin
          dec_en = 1'b1;
          if (q_one) begin
            tc_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            state_next = RUN;
`else
            state_next = DONE;
`endif
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (load) begin
          cell_load  = 1'b1;
          reload_we  = 1'b1;
          state_next = IDLE;
        end else if (start) begin
          cell_load  = 1'b1;
          cell_data  = reload;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reload register and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= {WIDTH{Q_BIT_RST}};
      tc     <= FLAG_RST;
      busy   <= FLAG_RST;
      done   <= FLAG_RST;
    end else begin
      if (reload_we) begin
        reload <= load_val;
      end
      tc   <= tc_next;
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule
